conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 124 ++++++++++++
 tb/tb_conv_window_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding F x F window generator for a raster-order pixel
// stream. Pixels arrive row-major; once F rows and F columns of the current
// frame are available, every accepted pixel produces one window covering the
// F x F neighbourhood whose bottom-right corner is that pixel.
//
// Ports:
//   clk      - clock, all state changes on its rising edge
//   resetn   - asynchronous active-low reset
//   s_valid  - upstream pixel valid
//   s_ready  - pixel accepted this cycle when s_valid is also high
//   s_data   - pixel value (DATA_WIDTH bits)
//   m_valid  - window valid toward the convolution stage
//   m_ready  - convolution stage accepts the window
//   m_data   - flattened window, element (r,c) at [(r*F+c)*DATA_WIDTH +: DATA_WIDTH]
//   m_last   - final window of a frame, qualified by m_valid
module conv_window_gen #(
  parameter int H          = 24,
  parameter int W          = 24,
  parameter int F          = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [F*F*DATA_WIDTH-1:0]    m_data,
  output logic                         m_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(F - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(F - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  // lbuf[k] holds image row (row-F+1+k); lbuf[F-2] is the row just above.
  logic [DATA_WIDTH-1:0] lbuf    [F-1][W];
  logic [DATA_WIDTH-1:0] win     [F][F];
  logic [DATA_WIDTH-1:0] new_col [F];
  logic                  accept;
  logic                  load;
  logic                  frame_end;

  assign s_ready   = !m_valid || m_ready;
  assign accept    = s_valid && s_ready;
  // Only pixels with a full F x F neighbourhood inside the current frame
  // produce a window, so stale line-buffer data (previous frame, or left
  // over from a reset) never reaches m_data.
  assign load      = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  // Column entering the window: F-1 buffered pixels above plus the new pixel.
  always_comb begin
    for (int unsigned r = 0; r < F; r++) new_col[r] = '0;
    for (int unsigned r = 0; r < F - 1; r++) new_col[r] = lbuf[r][col];
    new_col[F-1] = s_data;
  end

  // Line buffers advance vertically at the current column: each row slot
  // moves up by one and the new pixel becomes the newest buffered row.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned r = 0; r + 2 < F; r++) lbuf[r][col] <= lbuf[r+1][col];
      lbuf[F-2][col] <= s_data;
    end
  end

  // Window register doubles as the output data register: it only moves on an
  // accepted pixel, and no pixel is accepted while a window is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < F; r++)
        for (int unsigned c = 0; c < F; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < F; r++) begin
        for (int unsigned c = 0; c + 1 < F; c++) win[r][c] <= win[r][c+1];
        win[r][F-1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (load) begin
        m_valid <= 1'b1;
        m_last  <= frame_end;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    m_data = '0;
    for (int unsigned r = 0; r < F; r++)
      for (int unsigned c = 0; c < F; c++)
        m_data[(r*F+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: frames are described as images,
// expected windows are cut directly out of the image array.
module tb_conv_window_gen;
  localparam int H  = 24;
  localparam int W  = 24;
  localparam int F  = 5;
  localparam int DW = 8;
  localparam int MW = F*F*DW;

  typedef struct {
    logic [MW-1:0] data;
    logic          last;
  } win_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [MW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  conv_window_gen #(.H(H), .W(W), .F(F), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] in_q [$];
  win_t          exp_q [$];
  logic [DW-1:0] img [H][W];
  int            acc_count, xfer_count, last_count, first_acc;
  bit            seen_first;
  logic [MW-1:0] first_win, last_win;
  logic          last_win_flag;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue the frame's pixels and every window the frame must yield.
  task automatic build_frame();
    win_t w;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        in_q.push_back(img[y][x]);
    for (int y = F - 1; y < H; y++)
      for (int x = F - 1; x < W; x++) begin
        w.data = '0;
        for (int r = 0; r < F; r++)
          for (int c = 0; c < F; c++)
            w.data[(r*F+c)*DW +: DW] = img[y-F+1+r][x-F+1+c];
        w.last = (y == H - 1) && (x == W - 1);
        exp_q.push_back(w);
      end
  endtask

  task automatic start_test();
    acc_count = 0; xfer_count = 0; last_count = 0;
    first_acc = -1; seen_first = 1'b0;
  endtask

  // One cycle: drive inputs after the falling edge, judge the handshakes
  // that the coming rising edge will perform.
  task automatic tick(input int vpct, input int rpct);
    win_t e;
    @(negedge clk);
    s_valid = (in_q.size() > 0) && (int'($urandom_range(99)) < vpct);
    s_data  = (in_q.size() > 0) ? in_q[0] : '0;
    m_ready = (int'($urandom_range(99)) < rpct);
    #1;
    if (!seen_first && m_valid) begin
      seen_first = 1'b1;
      first_acc  = acc_count;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_window observed=%0h expected=none", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("window_data", m_data, e.data);
        chk("window_last", MW'(m_last), MW'(e.last));
        if (xfer_count == 0) first_win = m_data;
        last_win      = m_data;
        last_win_flag = m_last;
        xfer_count++;
        if (m_last) last_count++;
      end
    end
    if (s_valid && s_ready) begin
      void'(in_q.pop_front());
      acc_count++;
    end
  endtask

  task automatic drain(input int vpct, input int rpct, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && n < budget) begin
      tick(vpct, rpct);
      n++;
    end
    chk("drain_left", MW'(exp_q.size() + in_q.size()), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, MW'(m_valid), '0);
    chk({tag, "_m_last"},  MW'(m_last),  '0);
    chk({tag, "_m_data"},  m_data,       '0);
    chk({tag, "_s_ready"}, MW'(s_ready), MW'(1));
  endtask

  initial begin
    logic [MW-1:0] held;
    logic          held_last;
    int            acc_snap;
    int            n;

    // Reset behaviour before any clock edge.
    resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    #1;
    check_reset_outputs("reset_initial");
    #20;
    @(negedge clk);
    resetn = 1'b1;

    // Full-rate ramp frame.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'((y*W + x) % 256);
    start_test();
    build_frame();
    drain(100, 100, 2000);
    chk("first_latency", MW'(first_acc), MW'(101));
    chk("first_elem00", MW'(first_win[0 +: DW]), '0);
    chk("first_elem44", MW'(first_win[(4*F+4)*DW +: DW]), MW'(100));
    chk("ramp_count", MW'(xfer_count), MW'(400));
    chk("last_elem44", MW'(last_win[(4*F+4)*DW +: DW]), MW'(63));
    chk("last_flag", MW'(last_win_flag), MW'(1));
    chk("ramp_last_count", MW'(last_count), MW'(1));

    // Output stall: m_ready low while a window is pending.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'((y*W + x + 17) % 256);
    start_test();
    build_frame();
    n = 0;
    tick(100, 0);
    while (!m_valid && n < 300) begin
      tick(100, 0);
      n++;
    end
    chk("stall_reached", MW'(m_valid), MW'(1));
    held      = m_data;
    held_last = m_last;
    acc_snap  = acc_count;
    for (int i = 0; i < 10; i++) begin
      tick(100, 0);
      chk("stall_valid", MW'(m_valid), MW'(1));
      chk("stall_data", m_data, held);
      chk("stall_last", MW'(m_last), MW'(held_last));
      chk("stall_s_ready", MW'(s_ready), '0);
      chk("stall_no_accept", MW'(acc_count), MW'(acc_snap));
    end
    drain(100, 100, 2000);
    chk("stall_count", MW'(xfer_count), MW'(400));

    // Random gaps on both sides over a random-content frame.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'($urandom);
    start_test();
    build_frame();
    drain(60, 50, 20000);
    chk("random_count", MW'(xfer_count), MW'(400));
    chk("random_last_count", MW'(last_count), MW'(1));

    // Reset in the middle of a frame, then a fresh frame.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'((y*W + x + 99) % 256);
    start_test();
    build_frame();
    n = 0;
    while (acc_count < 250 && n < 1000) begin
      tick(100, 100);
      n++;
    end
    chk("pre_reset_accepts", MW'(acc_count), MW'(250));
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    in_q.delete();
    exp_q.delete();
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'($urandom);
    start_test();
    build_frame();
    drain(80, 70, 20000);
    chk("post_reset_count", MW'(xfer_count), MW'(400));
    chk("post_reset_elem00", MW'(first_win[0 +: DW]), MW'(img[0][0]));

    // Two back-to-back frames with different ramps.
    start_test();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'((3*(y*W + x) + 7) % 256);
    build_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = DW'((255 - (y*W + x)) % 256);
    build_frame();
    drain(100, 100, 3000);
    chk("b2b_count", MW'(xfer_count), MW'(800));
    chk("b2b_last_count", MW'(last_count), MW'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
